// File: rtl/serv_alu_pkg.sv
// Shared opcode encoding, FSM state type and opcode decode helpers for the
// chunk-serial ALU.
package serv_alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLT  = 4'd2,
        OP_SLTU = 4'd3,
        OP_EQ   = 4'd4,
        OP_XOR  = 4'd5,
        OP_OR   = 4'd6,
        OP_AND  = 4'd7,
        OP_MIN  = 4'd8,
        OP_MAX  = 4'd9,
        OP_MINU = 4'd10,
        OP_MAXU = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_OUT
    } alu_state_e;

    // Ops that must see the whole operand pair before any result chunk exists.
    function automatic logic is_two_pass(input logic [3:0] op);
        case (op)
            OP_SLT, OP_SLTU, OP_MIN, OP_MAX, OP_MINU, OP_MAXU: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        case (op)
            OP_SUB, OP_SLT, OP_SLTU, OP_EQ,
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_cmp(input logic [3:0] op);
        case (op)
            OP_SLT, OP_MIN, OP_MAX: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serv_alu_slice.sv
// One W-bit chunk of the datapath: adder/subtractor with carry, bitwise ops
// and a zero detect on the adder result.
module serv_alu_slice #(
    parameter int W = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic [W-1:0] o_xor,
    output logic [W-1:0] o_or,
    output logic [W-1:0] o_and,
    output logic         o_zero
);

    logic [W-1:0] w_b_add;

    assign w_b_add         = i_b ^ {W{i_sub}};
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b_add} + (W+1)'(i_cin);
    assign o_xor           = i_a ^ i_b;
    assign o_or            = i_a | i_b;
    assign o_and           = i_a & i_b;
    assign o_zero          = (o_sum == '0);

endmodule

// File: rtl/serv_alu_seq.sv
// Chunk-serial RISC-V style ALU: operands arrive W bits per cycle LSB-first;
// compare-derived ops buffer both operands and replay the selected one.
module serv_alu_seq
    import serv_alu_pkg::*;
#(
    parameter int W    = 1,
    parameter int XLEN = serv_alu_pkg::XLEN
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_op_b,
    output logic [W-1:0] o_rd,
    output logic         o_rd_valid,
    output logic         o_cmp,
    output logic         o_busy,
    output logic         o_done
);

    localparam int N = XLEN / W;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    alu_state_e      r_state;
    alu_state_e      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_op;
    logic            r_carry;
    logic            r_eq;
    logic            r_cmp;
    logic [XLEN-1:0] r_rs1_buf;
    logic [XLEN-1:0] r_opb_buf;

    logic            w_accept;
    logic            w_calc;
    logic            w_first;
    logic            w_last_calc;
    logic [3:0]      w_op;
    logic            w_cin;
    logic [W-1:0]    w_sum;
    logic            w_cout;
    logic [W-1:0]    w_xor;
    logic [W-1:0]    w_or;
    logic [W-1:0]    w_and;
    logic            w_zero;
    logic            w_eq;
    logic            w_lt;
    logic            w_cmp_nxt;
    logic [W-1:0]    w_sp_rd;
    logic [W-1:0]    w_out_rd;

    assign w_accept    = (r_state == ST_IDLE) && i_start && i_rst_n;
    assign w_calc      = w_accept || (r_state == ST_CALC);
    assign w_first     = (r_state == ST_IDLE);
    assign w_last_calc = (r_state == ST_CALC) && (r_cnt == LAST);
    assign w_op        = w_first ? i_op : r_op;
    assign w_cin       = w_first ? is_sub(w_op) : r_carry;

    serv_alu_slice #(.W(W)) u_slice (
        .i_a    (i_rs1),
        .i_b    (i_op_b),
        .i_sub  (is_sub(w_op)),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_xor  (w_xor),
        .o_or   (w_or),
        .o_and  (w_and),
        .o_zero (w_zero)
    );

    // Bit XLEN of the extended difference: extension bits of rs1 and ~op_b plus the carry.
    assign w_eq = (w_first ? 1'b1 : r_eq) & w_zero;
    assign w_lt = (is_signed_cmp(w_op) & i_rs1[W-1])
                ^ ~(is_signed_cmp(w_op) & i_op_b[W-1])
                ^ w_cout;

    always_comb begin
        w_cmp_nxt = 1'b0;
        if (w_op == OP_EQ)
            w_cmp_nxt = w_eq;
        else if (w_op <= OP_MAXU)
            w_cmp_nxt = w_lt;
    end

    always_comb begin
        w_sp_rd = '0;
        case (w_op)
            OP_ADD, OP_SUB: w_sp_rd = w_sum;
            OP_XOR:         w_sp_rd = w_xor;
            OP_OR:          w_sp_rd = w_or;
            OP_AND:         w_sp_rd = w_and;
            default:        w_sp_rd = '0;
        endcase
    end

    always_comb begin
        w_out_rd = '0;
        case (r_op)
            OP_SLT, OP_SLTU: w_out_rd = (r_cnt == '0) ? W'(r_cmp) : '0;
            OP_MIN, OP_MINU: w_out_rd = r_cmp ? r_rs1_buf[W-1:0] : r_opb_buf[W-1:0];
            OP_MAX, OP_MAXU: w_out_rd = r_cmp ? r_opb_buf[W-1:0] : r_rs1_buf[W-1:0];
            default:         w_out_rd = '0;
        endcase
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        o_rd        = '0;
        o_rd_valid  = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    o_busy      = 1'b1;
                    w_state_nxt = ST_CALC;
                    if (!is_two_pass(i_op)) begin
                        o_rd_valid = 1'b1;
                        o_rd       = w_sp_rd;
                    end
                end
            end
            ST_CALC: begin
                o_busy = 1'b1;
                if (!is_two_pass(r_op)) begin
                    o_rd_valid = 1'b1;
                    o_rd       = w_sp_rd;
                end
                if (r_cnt == LAST) begin
                    w_state_nxt = is_two_pass(r_op) ? ST_OUT : ST_IDLE;
                    o_done      = !is_two_pass(r_op);
                end
            end
            ST_OUT: begin
                o_busy     = 1'b1;
                o_rd_valid = 1'b1;
                o_rd       = w_out_rd;
                if (r_cnt == LAST) begin
                    o_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_cmp = r_cmp;

    // NOTE: the operand buffers are plain flops, so they are cleared with the rest of the state.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_carry   <= 1'b0;
            r_eq      <= 1'b0;
            r_cmp     <= 1'b0;
            r_rs1_buf <= '0;
            r_opb_buf <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= i_op;
                r_cmp <= 1'b0;
                r_cnt <= CW'(1);
            end else if (r_state != ST_IDLE) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
            end
            if (w_calc) begin
                r_carry   <= w_cout;
                r_eq      <= w_eq;
                r_rs1_buf <= {i_rs1, r_rs1_buf[XLEN-1:W]};
                r_opb_buf <= {i_op_b, r_opb_buf[XLEN-1:W]};
                if (w_last_calc)
                    r_cmp <= w_cmp_nxt;
            end else if (r_state == ST_OUT) begin
                r_rs1_buf <= {{W{1'b0}}, r_rs1_buf[XLEN-1:W]};
                r_opb_buf <= {{W{1'b0}}, r_opb_buf[XLEN-1:W]};
            end
        end
    end

endmodule

// File: tb/tb_serv_alu_seq.sv
// Bench for serv_alu_seq: three instances (W=1,4,8) share one stimulus bus and
// are checked against a whole-word arithmetic reference model.
module tb_serv_alu_seq;

    localparam int XLEN = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        bit          cc;
        int          lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_start;
    logic [3:0] d_op;
    logic [7:0] d_rs1;
    logic [7:0] d_opb;
    int         cur_w;
    int         checks = 0;
    int         errors = 0;

    logic       st1, st4, st8;
    logic [0:0] rd1;
    logic [3:0] rd4;
    logic [7:0] rd8;
    logic       v1, v4, v8, c1, c4, c8, b1, b4, b8, dn1, dn4, dn8;
    logic [7:0] s_rd;
    logic       s_valid, s_cmp, s_busy, s_done;

    always #5 clk = ~clk;

    assign st1 = d_start && (cur_w == 1);
    assign st4 = d_start && (cur_w == 4);
    assign st8 = d_start && (cur_w == 8);

    serv_alu_seq #(.W(1), .XLEN(XLEN)) u_dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_start(st1), .i_op(d_op),
        .i_rs1(d_rs1[0:0]), .i_op_b(d_opb[0:0]), .o_rd(rd1), .o_rd_valid(v1),
        .o_cmp(c1), .o_busy(b1), .o_done(dn1));
    serv_alu_seq #(.W(4), .XLEN(XLEN)) u_dut4 (
        .clk(clk), .i_rst_n(rst_n), .i_start(st4), .i_op(d_op),
        .i_rs1(d_rs1[3:0]), .i_op_b(d_opb[3:0]), .o_rd(rd4), .o_rd_valid(v4),
        .o_cmp(c4), .o_busy(b4), .o_done(dn4));
    serv_alu_seq #(.W(8), .XLEN(XLEN)) u_dut8 (
        .clk(clk), .i_rst_n(rst_n), .i_start(st8), .i_op(d_op),
        .i_rs1(d_rs1), .i_op_b(d_opb), .o_rd(rd8), .o_rd_valid(v8),
        .o_cmp(c8), .o_busy(b8), .o_done(dn8));

    always_comb begin
        case (cur_w)
            1: begin s_rd = {7'b0, rd1}; s_valid = v1; s_cmp = c1; s_busy = b1; s_done = dn1; end
            4: begin s_rd = {4'b0, rd4}; s_valid = v4; s_cmp = c4; s_busy = b4; s_done = dn4; end
            default: begin s_rd = rd8; s_valid = v8; s_cmp = c8; s_busy = b8; s_done = dn8; end
        endcase
    end

    // Reference: whole-word results straight from the opcode definitions.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output bit cc, output int lat);
        logic signed [31:0] sa, sb;
        int n;
        sa = a; sb = b; n = XLEN / cur_w;
        r = 32'h0; c = 1'b0; cc = 1'b1; lat = n;
        case (op)
            4'd0:  begin r = a + b; cc = 0; end
            4'd1:  begin r = a - b; c = (a < b); end
            4'd2:  begin c = (sa < sb); r = {31'b0, c}; lat = 2 * n; end
            4'd3:  begin c = (a < b);   r = {31'b0, c}; lat = 2 * n; end
            4'd4:  begin c = (a == b); end
            4'd5:  begin r = a ^ b; cc = 0; end
            4'd6:  begin r = a | b; cc = 0; end
            4'd7:  begin r = a & b; cc = 0; end
            4'd8:  begin c = (sa < sb); r = c ? a : b; lat = 2 * n; end
            4'd9:  begin c = (sa < sb); r = c ? b : a; lat = 2 * n; end
            4'd10: begin c = (a < b);   r = c ? a : b; lat = 2 * n; end
            4'd11: begin c = (a < b);   r = c ? b : a; lat = 2 * n; end
            default: begin r = 32'h0; c = 1'b0; end
        endcase
    endfunction

    // Drives one operation chunk by chunk on the selected instance and gathers what it emits.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int restart_at, input int rst_at,
                         output logic [31:0] res, output int nvalid, output int done_cyc,
                         output logic cmp, output bit bad_rd, output bit bad_rst);
        int n, max_t, mask;
        bit fin;
        logic [31:0] sh_a, sh_b, chunk;
        n = XLEN / cur_w;
        max_t = (rst_at > 0) ? 2 * n + 2 : 2 * n + 4;
        mask = (1 << cur_w) - 1;
        res = 0; nvalid = 0; done_cyc = 0; cmp = 0; bad_rd = 0; bad_rst = 0; fin = 0;
        for (int t = 1; t <= max_t && !fin; t++) begin
            @(negedge clk);
            d_start = (t == 1) || (t == restart_at);
            d_op = (t == 1) ? op : 4'($urandom);
            if (t <= n) begin
                sh_a = a >> ((t - 1) * cur_w);
                sh_b = b >> ((t - 1) * cur_w);
                d_rs1 = sh_a[7:0];
                d_opb = sh_b[7:0];
            end else begin
                d_rs1 = 8'($urandom);
                d_opb = 8'($urandom);
            end
            if (rst_at > 0) rst_n = (t != rst_at);
            #1;
            if (s_done === 1'b1) done_cyc = t;
            if (rst_at > 0 && t > rst_at) begin
                if (s_rd !== 8'h0 || s_valid !== 1'b0 || s_busy !== 1'b0 ||
                    s_done !== 1'b0 || s_cmp !== 1'b0) bad_rst = 1;
            end else begin
                if (s_valid !== 1'b1 && s_rd !== 8'h0) bad_rd = 1;
                if (s_valid === 1'b1) begin
                    chunk = 32'(s_rd) & 32'(mask);
                    res |= chunk << (nvalid * cur_w);
                    nvalid++;
                end
                if (s_done === 1'b1 && rst_at == 0) fin = 1;
            end
        end
        @(posedge clk);
        #1;
        cmp = s_cmp;
        d_start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d_start = 1'b1;
        d_op = 4'd0;
        repeat (3) @(negedge clk);
        d_start = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cur_w = (k == 0) ? 1 : (k == 1) ? 4 : 8;
            #1;
            checks++;
            if ({s_rd, s_valid, s_busy, s_done, s_cmp} !== 12'h0) begin
                errors++;
                $display("FAIL reset_state w=%0d got rd=%h v=%b busy=%b done=%b cmp=%b want all 0",
                         cur_w, s_rd, s_valid, s_busy, s_done, s_cmp);
            end
        end
    endtask

    task automatic test_directed();
        vec_t v [8];
        logic [31:0] res;
        int nv, dc;
        logic cmp;
        bit brd, brs;
        cur_w = 4;
        v[0] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 8};
        v[1] = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b1, 8};
        v[2] = '{4'd4,  32'h1234ABCD, 32'h1234ABCD, 32'h00000000, 1'b1, 1'b1, 8};
        v[3] = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 16};
        v[4] = '{4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 16};
        v[5] = '{4'd8,  32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 16};
        v[6] = '{4'd11, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 16};
        v[7] = '{4'd10, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, 16};
        for (int i = 0; i < 8; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, 0, 0, res, nv, dc, cmp, brd, brs);
            checks++;
            if (res !== v[i].r) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, v[i].r); end
            checks++;
            if (nv !== 8) begin errors++; $display("FAIL dir%0d_chunks got %0d want 8", i, nv); end
            checks++;
            if (dc !== v[i].lat) begin errors++; $display("FAIL dir%0d_done_cycle got %0d want %0d", i, dc, v[i].lat); end
            checks++;
            if (s_busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_after got %b want 0", i, s_busy); end
            checks++;
            if (brd) begin errors++; $display("FAIL dir%0d_rd_when_invalid got nonzero want 0", i); end
            if (v[i].cc) begin
                checks++;
                if (cmp !== v[i].c) begin errors++; $display("FAIL dir%0d_cmp got %b want %b", i, cmp, v[i].c); end
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] res;
        int nv, dc;
        logic cmp;
        bit brd, brs;
        cur_w = 4;
        do_op(4'd0, 32'h12345678, 32'h11111111, 3, 0, res, nv, dc, cmp, brd, brs);
        checks++;
        if (res !== 32'h23456789) begin errors++; $display("FAIL ignore_start_add got %h want 23456789", res); end
        checks++;
        if (dc !== 8) begin errors++; $display("FAIL ignore_start_add_done got %0d want 8", dc); end
        do_op(4'd8, 32'h00000010, 32'hFFFFFFF0, 12, 0, res, nv, dc, cmp, brd, brs);
        checks++;
        if (res !== 32'hFFFFFFF0 || dc !== 16) begin
            errors++; $display("FAIL ignore_start_min got %h/%0d want fffffff0/16", res, dc);
        end
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle got busy=%b want 0", s_busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int nv, dc;
        logic cmp;
        bit brd, brs;
        cur_w = 4;
        do_op(4'd9, 32'h00000003, 32'h00000009, 0, 0, res, nv, dc, cmp, brd, brs);
        checks++;
        if (res !== 32'h9 || dc !== 16) begin errors++; $display("FAIL b2b_first got %h/%0d want 9/16", res, dc); end
        do_op(4'd1, 32'h00001000, 32'h00000001, 0, 0, res, nv, dc, cmp, brd, brs);
        checks++;
        if (res !== 32'h00000FFF || dc !== 8) begin errors++; $display("FAIL b2b_second got %h/%0d want fff/8", res, dc); end
        do_op(4'd6, 32'hF0F00000, 32'h0000F0F0, 0, 0, res, nv, dc, cmp, brd, brs);
        checks++;
        if (res !== 32'hF0F0F0F0 || dc !== 8) begin errors++; $display("FAIL b2b_third got %h/%0d want f0f0f0f0/8", res, dc); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int nv, dc;
        logic cmp;
        bit brd, brs;
        cur_w = 4;
        do_op(4'd9, 32'h7FFFFFFF, 32'h80000000, 0, 4, res, nv, dc, cmp, brd, brs);
        checks++;
        if (brs) begin errors++; $display("FAIL reset_mid_outputs got nonzero after reset want all 0"); end
        checks++;
        if (dc !== 0) begin errors++; $display("FAIL reset_mid_done got done at cycle %0d want none", dc); end
        do_op(4'd0, 32'h00000002, 32'h00000003, 0, 0, res, nv, dc, cmp, brd, brs);
        checks++;
        if (res !== 32'h5 || dc !== 8) begin errors++; $display("FAIL reset_mid_next_add got %h/%0d want 5/8", res, dc); end
    endtask

    task automatic test_widths();
        logic [31:0] res;
        int nv, dc, n;
        logic cmp;
        bit brd, brs;
        for (int k = 0; k < 2; k++) begin
            cur_w = (k == 0) ? 1 : 8;
            n = XLEN / cur_w;
            do_op(4'd0, 32'hFFFFFFFF, 32'h00000001, 0, 0, res, nv, dc, cmp, brd, brs);
            checks++;
            if (res !== 32'h0 || nv !== n || dc !== n) begin
                errors++; $display("FAIL w%0d_add got %h/%0d/%0d want 0/%0d/%0d", cur_w, res, nv, dc, n, n);
            end
            do_op(4'd2, 32'hFFFFFFFF, 32'h00000001, 0, 0, res, nv, dc, cmp, brd, brs);
            checks++;
            if (res !== 32'h1 || cmp !== 1'b1 || nv !== n || dc !== 2 * n) begin
                errors++; $display("FAIL w%0d_slt got %h/%b/%0d/%0d want 1/1/%0d/%0d", cur_w, res, cmp, nv, dc, n, 2 * n);
            end
            do_op(4'd8, 32'h80000000, 32'h7FFFFFFF, 0, 0, res, nv, dc, cmp, brd, brs);
            checks++;
            if (res !== 32'h80000000 || nv !== n || dc !== 2 * n) begin
                errors++; $display("FAIL w%0d_min got %h/%0d/%0d want 80000000/%0d/%0d", cur_w, res, nv, dc, n, 2 * n);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, er;
        logic [3:0] op;
        int nv, dc, elat;
        logic cmp, ec;
        bit brd, brs, ecc;
        for (int k = 0; k < 3; k++) begin
            cur_w = (k == 0) ? 1 : (k == 1) ? 4 : 8;
            for (int i = 0; i < 25; i++) begin
                op = 4'($urandom_range(0, 15));
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = a;
                    1: b = a ^ 32'h80000000;
                    2: b = a + 32'($urandom_range(0, 2)) - 32'd1;
                    default: b = $urandom;
                endcase
                model(op, a, b, er, ec, ecc, elat);
                do_op(op, a, b, 0, 0, res, nv, dc, cmp, brd, brs);
                checks++;
                if (res !== er || nv !== XLEN / cur_w || dc !== elat || brd) begin
                    errors++;
                    $display("FAIL rand_w%0d_op%0d a=%h b=%h got %h/%0d/%0d/%b want %h/%0d/%0d/0",
                             cur_w, op, a, b, res, nv, dc, brd, er, XLEN / cur_w, elat);
                end
                if (ecc) begin
                    checks++;
                    if (cmp !== ec) begin
                        errors++; $display("FAIL rand_w%0d_op%0d_cmp a=%h b=%h got %b want %b", cur_w, op, a, b, cmp, ec);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d_start = 1'b0;
        d_op = 4'd0;
        d_rs1 = 8'h0;
        d_opb = 8'h0;
        cur_w = 4;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_widths();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serv_alu_seq.md
SERV_ALU_SEQ -- requirements
Module: serv_alu_seq

Interface
REQ-001 Parameter W, default 1: data chunk width in bits per cycle; legal values 1, 2, 4, 8.
REQ-002 Parameter XLEN, default 32: operand width; N = XLEN/W chunks per operand.
REQ-003 Port list, clock and reset first:
  clk  in  1  sole clock, rising edge.
  i_rst_n  in  1  reset, synchronous, active-low.
  i_start  in  1  operation start; chunk 0 is presented in the same cycle.
  i_op  in  4  opcode: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 EQ, 5 XOR, 6 OR, 7 AND, 8 MIN, 9 MAX, 10 MINU, 11 MAXU, 12-15 reserved.
  i_rs1  in  W  rs1 chunk, LSB-first.
  i_op_b  in  W  operand-B chunk, LSB-first.
  o_rd  out  W  result chunk, LSB-first.
  o_rd_valid  out  1  o_rd carries a result chunk.
  o_cmp  out  1  compare result (lt, or eq for EQ).
  o_busy  out  1  operation in progress.
  o_done  out  1  single-cycle pulse on the last result chunk.

Function
REQ-004 FSM states: IDLE, CALC, OUT. i_start is accepted only in IDLE; i_start in CALC or OUT is ignored.
REQ-005 The start cycle consumes chunk 0 and latches i_op; chunks 1..N-1 follow on consecutive cycles in CALC; i_op is ignored after the start cycle.
REQ-006 Single-pass ops (ADD, SUB, XOR, OR, AND, EQ) drive o_rd combinationally in the same cycle as the input chunk, with o_rd_valid high for N cycles and o_done on chunk N-1; the FSM then goes CALC->IDLE.
REQ-007 Two-pass ops (SLT, SLTU, MIN, MAX, MINU, MAXU) shift both operands into XLEN-bit buffers during CALC with o_rd_valid low, then emit N chunks in OUT on consecutive cycles; o_done is asserted on the last chunk and the FSM then goes OUT->IDLE.
REQ-008 Latency: a single-pass op occupies N cycles, a two-pass op occupies 2N cycles; i_start is accepted again in the cycle after o_done.
REQ-009 Adder: B = i_op_b XOR sub. The carry-in of chunk 0 is 1 for SUB, SLT, SLTU, EQ, MIN, MAX, MINU and MAXU, and 0 otherwise. The carry of chunk k feeds chunk k+1 through a register. Results are modulo 2^XLEN.
REQ-010 lt is bit XLEN of the (XLEN+1)-bit difference of rs1 and op_b, sign-extended for SLT, MIN and MAX and zero-extended otherwise; it is evaluated at chunk N-1.
REQ-011 eq is 1 when every difference chunk is zero; it accumulates from chunk 0 without depending on the previous operation.
REQ-012 o_cmp is registered at chunk N-1, shows eq for EQ and lt for all other ops, and holds until the next accepted start.
REQ-013 In OUT:
  SLT/SLTU emit {0...0, lt} in chunk 0 and zero in later chunks.
  MIN/MINU emit rs1 if lt, else op_b.
  MAX/MAXU emit op_b if lt, else rs1.
REQ-014 EQ and reserved opcodes drive o_rd = 0 while o_rd_valid is high, with normal timing; reserved opcodes leave o_cmp = 0.
REQ-015 o_rd is 0 whenever o_rd_valid is low.
REQ-016 o_busy is high from the start cycle through the o_done cycle.

Reset
REQ-017 When i_rst_n is low at a clock edge: the FSM goes to IDLE; the carry, eq accumulator, operand buffers and o_cmp clear to 0; o_rd, o_rd_valid, o_busy and o_done read 0 from the following cycle.
REQ-018 Reset asserted mid-operation discards that operation; no o_done is emitted for it.
REQ-019 i_start is ignored while i_rst_n is low.

Structure
REQ-020 Package serv_alu_pkg holds the opcode constants, XLEN, and a two-pass-op decode function.
REQ-021 One sub-module, serv_alu_slice, is purely combinational and contains the W-bit adder with carry, the bool ops and the chunk-zero detect; the FSM, chunk counter (log2 N bits, wrapping at N-1) and buffers stay in the top level.

Verification
REQ-022 Directed scenarios, W=4, XLEN=32:
  ADD 0xFFFFFFFF+0x00000001 -> 8 chunks of 0x0, o_done on the 8th cycle, o_busy low on the 9th cycle.
  SUB 0x00000005-0x00000007 -> 0xFFFFFFFE; EQ 0x1234ABCD vs 0x1234ABCD -> o_cmp=1, o_rd chunks all 0.
  SLT 0xFFFFFFFF vs 0x00000001 -> o_cmp=1, OUT chunk0=0x1; SLTU with the same operands -> o_cmp=0, all chunks 0; o_done at cycle 16.
  MIN 0x80000000 vs 0x7FFFFFFF -> 0x80000000; MAXU with the same operands -> 0x80000000; MINU -> 0x7FFFFFFF.
  i_start pulsed during CALC of an ADD -> ignored, result unchanged; a new start in the cycle after o_done -> accepted.
  i_rst_n low at chunk 3 of a MAX -> IDLE, all outputs 0, no o_done; the next ADD 2+3 -> 0x00000005.
REQ-023 Repeat the ADD, SLT and MIN scenarios for W=1 and W=8, checking chunk counts of 32 and 4.
